conv_mac_sequencer: RTL and testbench

Sequencer that computes one 3x3 convolution output pixel by driving the shared 32-bit ALU through nine multiply-accumulate steps. It sits between the data memory port and the ALU in the image-convolution processor:
- fetches pixel and kernel words;
- issues MUL and ADD operations on the ALU control bus;
- keeps the running sum;
- presents the final value with a one-cycle done pulse.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_tap_addr_gen.sv | 62 ++++++
 rtl/conv_mac_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_conv_mac_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the image-convolution sequencer.
//   - ALU opcodes driven on alu_ctrl
//   - sequencer state encoding
//   - number of taps in a 3x3 window
package conv_pkg;

  localparam logic [3:0] ALU_NOP      = 4'b0000;
  localparam logic [3:0] ALU_ADD      = 4'b0001;
  localparam logic [3:0] ALU_SUB      = 4'b0010;
  localparam logic [3:0] ALU_MUL      = 4'b0011;
  localparam logic [3:0] ALU_MOD      = 4'b0100;
  localparam logic [3:0] ALU_PASSATOC = 4'b0101;
  localparam logic [3:0] ALU_PASSBTOC = 4'b0110;
  localparam logic [3:0] ALU_INCAC    = 4'b0111;
  localparam logic [3:0] ALU_DECAC    = 4'b1000;
  localparam logic [3:0] ALU_RESET    = 4'b1001;

  localparam int KTAPS = 9;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RD_PIX = 4'd1,
    S_RD_KER = 4'd2,
    S_LD_KER = 4'd3,
    S_MUL_EN = 4'd4,
    S_MUL_WT = 4'd5,
    S_ADD_EN = 4'd6,
    S_ADD_WT = 4'd7,
    S_FIN    = 4'd8
  } seq_state_t;

endpackage

// File: rtl/conv_tap_addr_gen.sv
// conv_tap_addr_gen: tap counter and address generator for one 3x3 window.
//   clk, rst_n       clock, async active-low reset
//   clear            latch window/kernel bases and restart at tap (0,0)
//   advance          step to the next tap (c inner, r outer)
//   pix_base         top-left pixel address of the window
//   ker_base         address of kernel coefficient k0
//   last_tap         current tap is (2,2)
//   pix_addr         pix_base + r*IMG_W + c (wraps modulo 2^ADDR_W)
//   ker_addr         ker_base + 3*r + c     (wraps modulo 2^ADDR_W)
module conv_tap_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pix_base,
  input  logic [ADDR_W-1:0] ker_base,
  output logic              last_tap,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] ker_addr
);
  import conv_pkg::*;

  logic [1:0]        r;
  logic [1:0]        c;
  logic [3:0]        tap;
  logic [ADDR_W-1:0] pix_base_q;
  logic [ADDR_W-1:0] ker_base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r          <= '0;
      c          <= '0;
      tap        <= '0;
      pix_base_q <= '0;
      ker_base_q <= '0;
    end else if (clear) begin
      r          <= '0;
      c          <= '0;
      tap        <= '0;
      pix_base_q <= pix_base;
      ker_base_q <= ker_base;
    end else if (advance) begin
      tap <= last_tap ? 4'd0 : tap + 4'd1;
      if (c == 2'd2) begin
        c <= '0;
        r <= (r == 2'd2) ? 2'd0 : r + 2'd1;
      end else begin
        c <= c + 2'd1;
      end
    end
  end

  assign last_tap = (tap == 4'(KTAPS - 1));

  // Truncating casts give the modulo-2^ADDR_W wrap for free.
  assign pix_addr = pix_base_q + ADDR_W'(int'(r) * IMG_W) + ADDR_W'(c);
  assign ker_addr = ker_base_q + ADDR_W'(3 * int'(r)) + ADDR_W'(c);

endmodule

// File: rtl/conv_mac_sequencer.sv
// conv_mac_sequencer: computes one 3x3 convolution pixel as nine
// multiply-accumulate steps on the shared ALU.
//   clk, rst_n          clock, async active-low reset
//   start, abort        begin a pixel (IDLE only) / cancel back to IDLE
//   pix_base, ker_base  window and kernel base addresses, sampled with start
//   busy, done, result  status, one-cycle done pulse, accumulated sum
//   mem_rd, mem_addr    memory read port (mem_data valid one cycle later)
//   alu_en, alu_ctrl    ALU enable and opcode
//   alu_a, alu_b, alu_c ALU operand buses and result bus
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for start
// RD_PIX   | read pixel of current tap
// RD_KER   | capture pixel, read kernel coefficient
// LD_KER   | capture kernel coefficient
// MUL_EN   | issue MUL pix*ker
// MUL_WT   | wait ALU_LAT cycles, capture product at the end
// ADD_EN   | issue ADD acc+prod
// ADD_WT   | wait ALU_LAT cycles, capture acc, step tap
// FIN      | present result, pulse done
module conv_mac_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int IMG_W   = 256,
  parameter int ALU_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] pix_base,
  input  logic [ADDR_W-1:0] ker_base,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              alu_en,
  output logic [3:0]        alu_ctrl,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_c
);
  import conv_pkg::*;

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_tc;
  logic [31:0]       acc;
  logic [31:0]       pix_reg;
  logic [31:0]       ker_reg;
  logic [31:0]       prod_reg;
  logic [31:0]       result_q;
  logic [31:0]       alu_a_hold;
  logic [31:0]       alu_b_hold;
  logic              tap_clear;
  logic              tap_advance;
  logic              last_tap;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] ker_addr;

  assign wait_tc     = (wait_cnt == '0);
  assign tap_clear   = (state == S_IDLE) && start && !abort;
  assign tap_advance = (state == S_ADD_WT) && wait_tc && !abort;

  conv_tap_addr_gen #(
    .ADDR_W (ADDR_W),
    .IMG_W  (IMG_W)
  ) u_tap_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tap_clear),
    .advance  (tap_advance),
    .pix_base (pix_base),
    .ker_base (ker_base),
    .last_tap (last_tap),
    .pix_addr (pix_addr),
    .ker_addr (ker_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_RD_PIX;
        S_RD_PIX: state_nxt = S_RD_KER;
        S_RD_KER: state_nxt = S_LD_KER;
        S_LD_KER: state_nxt = S_MUL_EN;
        S_MUL_EN: state_nxt = S_MUL_WT;
        S_MUL_WT: if (wait_tc) state_nxt = S_ADD_EN;
        S_ADD_EN: state_nxt = S_ADD_WT;
        S_ADD_WT: if (wait_tc) state_nxt = last_tap ? S_FIN : S_RD_PIX;
        S_FIN:    state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_FIN) && !abort;
    mem_rd   = 1'b0;
    mem_addr = '0;
    alu_en   = 1'b0;
    alu_ctrl = ALU_NOP;
    alu_a    = alu_a_hold;
    alu_b    = alu_b_hold;
    case (state)
      S_RD_PIX: begin
        mem_rd   = 1'b1;
        mem_addr = pix_addr;
      end
      S_RD_KER: begin
        mem_rd   = 1'b1;
        mem_addr = ker_addr;
      end
      S_MUL_EN: begin
        alu_en   = 1'b1;
        alu_ctrl = ALU_MUL;
        alu_a    = pix_reg;
        alu_b    = ker_reg;
      end
      S_MUL_WT: alu_ctrl = ALU_MUL;
      S_ADD_EN: begin
        alu_en   = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_a    = acc;
        alu_b    = prod_reg;
      end
      S_ADD_WT: alu_ctrl = ALU_ADD;
      default: ;
    endcase
  end

  // Result is shown combinationally during FIN so it is valid with done.
  assign result = (state == S_FIN) ? acc : result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= '0;
      acc        <= '0;
      pix_reg    <= '0;
      ker_reg    <= '0;
      prod_reg   <= '0;
      result_q   <= '0;
      alu_a_hold <= '0;
      alu_b_hold <= '0;
    end else begin
      // Operand buses keep whatever was last presented.
      alu_a_hold <= alu_a;
      alu_b_hold <= alu_b;
      if (!abort) begin
        case (state)
          S_IDLE:   if (start) acc <= '0;
          S_RD_KER: pix_reg <= mem_data;
          S_LD_KER: ker_reg <= mem_data;
          S_MUL_EN: wait_cnt <= CNT_W'(ALU_LAT - 1);
          S_MUL_WT: begin
            if (wait_tc) prod_reg <= alu_c;
            else         wait_cnt <= wait_cnt - 1'b1;
          end
          S_ADD_EN: wait_cnt <= CNT_W'(ALU_LAT - 1);
          S_ADD_WT: begin
            if (wait_tc) acc      <= alu_c;
            else         wait_cnt <= wait_cnt - 1'b1;
          end
          S_FIN:    result_q <= acc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb_conv_mac_sequencer: directed bench for conv_mac_sequencer with a
// word memory model and a two-stage ALU model (latency 2).
module tb_conv_mac_sequencer;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pix_base = '0;
  logic [15:0] ker_base = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        alu_en;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c = '0;
  logic [31:0] alu_s1 = '0;

  always #5 clk = ~clk;

  conv_mac_sequencer #(
    .ADDR_W  (16),
    .IMG_W   (256),
    .ALU_LAT (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pix_base (pix_base),
    .ker_base (ker_base),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .alu_en   (alu_en),
    .alu_ctrl (alu_ctrl),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c)
  );

  logic [31:0] mem [0:65535];

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_MUL: return a * {16'h0000, b[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_en) alu_s1 <= alu_fn(alu_ctrl, alu_a, alu_b);
    alu_c <= alu_s1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] rd_q[$];
  logic [3:0]  ctl_q[$];
  int          n_alu, n_rd, lat, busy_low;
  bit          seen_done;
  logic [31:0] res_at_done;
  logic [3:0]  ctrl_at_abort;
  logic        en_at_abort;

  task automatic run_px(input logic [15:0] pb, input logic [15:0] kb, input int abort_at, input int spur_at);
    rd_q.delete();
    ctl_q.delete();
    n_alu = 0; n_rd = 0; lat = 0; busy_low = 0; seen_done = 0;
    res_at_done = '0; ctrl_at_abort = '0; en_at_abort = 1'b0;
    @(negedge clk);
    start = 1'b1; pix_base = pb; ker_base = kb;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 120; n++) begin
      if (mem_rd) begin rd_q.push_back(mem_addr); n_rd++; end
      if (alu_en) begin ctl_q.push_back(alu_ctrl); n_alu++; end
      if (!busy) busy_low++;
      if (done) begin seen_done = 1'b1; lat = n + 1; res_at_done = result; break; end
      if (abort_at >= 0 && n == abort_at + 1) break;
      if (n == abort_at) begin ctrl_at_abort = alu_ctrl; en_at_abort = alu_en; end
      abort    = (n == abort_at);
      start    = (n == spur_at);
      pix_base = (n == spur_at) ? ~pb : pb;
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; pix_base = pb;
  endtask

  task automatic check_normal(input string tag, input logic [31:0] exp_res);
    int bad;
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'd82);
    check({tag, "_result"}, res_at_done, exp_res);
    check({tag, "_alu_en_cnt"}, 64'(n_alu), 64'd18);
    check({tag, "_mem_rd_cnt"}, 64'(n_rd), 64'd18);
    check({tag, "_busy_gap"}, 64'(busy_low), 64'd0);
    bad = 0;
    foreach (ctl_q[i]) if (ctl_q[i] !== ((i % 2 == 0) ? ALU_MUL : ALU_ADD)) bad++;
    check({tag, "_ctrl_alt"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_width"}, 64'(done), 64'd0);
    check({tag, "_result_hold"}, result, exp_res);
  endtask

  task automatic load_window(input logic [15:0] pb, input logic [15:0] kb, input int mode);
    for (int k = 0; k < 9; k++) begin
      logic [15:0] pa;
      pa = pb + 16'((k / 3) * 256 + (k % 3));
      case (mode)
        0: begin mem[pa] = 32'd1; mem[kb + 16'(k)] = 32'd1; end
        1: begin mem[pa] = 32'(k + 1); mem[kb + 16'(k)] = 32'(9 - k); end
        2: begin mem[pa] = 32'hFFFF0000; mem[kb + 16'(k)] = 32'h00010002; end
        default: begin mem[pa] = 32'd2; mem[kb + 16'(k)] = 32'd3; end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] wrap_exp [9];
    wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001, 16'h00FF, 16'h0100,
                 16'h0101, 16'h01FF, 16'h0200, 16'h0201};
    for (int i = 0; i < 65536; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 32'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", mem_addr, 16'd0);
    check("rst_alu_en", 64'(alu_en), 64'd0);
    check("rst_alu_ctrl", alu_ctrl, 4'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    rst_n = 1'b1;

    // start with abort in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);
    check("idle_abort_rd", 64'(mem_rd), 64'd0);

    // all ones
    load_window(16'h0100, 16'h0000, 0);
    run_px(16'h0100, 16'h0000, -1, -1);
    for (int k = 0; k < 9; k++) begin
      check("ones_pix_addr", rd_q[2*k], 16'h0100 + 16'((k / 3) * 256 + (k % 3)));
      check("ones_ker_addr", rd_q[2*k+1], 16'(k));
    end
    check_normal("ones", 32'd9);

    // reset in the middle of tap 0 ADD_WT
    @(negedge clk);
    start = 1'b1; pix_base = 16'h0100; ker_base = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_ctrl", alu_ctrl, ALU_ADD);
    check("pre_rst_en", 64'(alu_en), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_ctrl", alu_ctrl, 4'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // pixels 1..9 x kernel 9..1, with a start raised while busy
    load_window(16'h1000, 16'h0020, 1);
    run_px(16'h1000, 16'h0020, -1, 20);
    check("seq_last_pix_addr", rd_q[16], 16'h1202);
    check("seq_last_ker_addr", rd_q[17], 16'h0028);
    check_normal("seq", 32'd165);

    // product truncation and sum wrap
    load_window(16'h2000, 16'h0030, 2);
    run_px(16'h2000, 16'h0030, -1, -1);
    check_normal("wrapsum", 32'hFFEE0000);

    // address wrap
    load_window(16'hFFFF, 16'h0040, 3);
    run_px(16'hFFFF, 16'h0040, -1, -1);
    for (int k = 0; k < 9; k++) check("wrap_pix_addr", rd_q[2*k], wrap_exp[k]);
    check("wrap_ker_addr", rd_q[17], 16'h0048);
    check_normal("wrapaddr", 32'd54);

    // abort during tap 5 MUL_WT
    run_px(16'h1000, 16'h0020, 40, -1);
    check("abort_ctrl", ctrl_at_abort, ALU_MUL);
    check("abort_en", 64'(en_at_abort), 64'd0);
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_idle", 64'(busy_low), 64'd1);
    check("abort_alu_en_cnt", 64'(n_alu), 64'd9);
    check("abort_result", result, 32'd54);
    @(negedge clk);
    check("abort_still_idle", 64'(busy), 64'd0);
    check("abort_done_low", 64'(done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
